// File: rtl/debug_send_fsm.sv
// debug_send_fsm: streams the PC, a register-file snapshot and data memory out as bytes over a UART, MSB first.
module debug_send_fsm #(
  parameter int PC_BITS         = 32,
  parameter int PROC_BITS       = 32,
  parameter int NUM_REGS        = 32,
  parameter int DATA_ADDRS_BITS = 7,
  parameter int MEM_WORDS       = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [PC_BITS-1:0]            i_pc,
  input  logic [NUM_REGS*PROC_BITS-1:0] i_rf_regs,
  input  logic [PROC_BITS-1:0]          i_mem_data,
  input  logic                          i_tx_done,
  output logic                          o_tx_start,
  output logic [7:0]                    o_tx_data,
  output logic                          o_debug_read_data,
  output logic [DATA_ADDRS_BITS-1:0]    o_debug_read_address,
  output logic                          o_busy,
  output logic                          o_done
);
  localparam int MAXW = NUM_REGS > MEM_WORDS ? NUM_REGS : MEM_WORDS;
  localparam int IW   = MAXW > 2 ? $clog2(MAXW) : 1;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, MEM_REQ, MEM_WAIT, DONE} state_t;
  typedef enum logic [1:0] {PH_PC, PH_REG, PH_MEM} phase_t;
  state_t                        state_q, state_d;
  phase_t                        phase_q, phase_d;
  logic [31:0]                   shift_q, shift_d;
  logic [NUM_REGS*PROC_BITS-1:0] snap_q, snap_d;
  logic [1:0]                    byte_q, byte_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [7:0]                    tx_data_q, tx_data_d;
  logic [DATA_ADDRS_BITS-1:0]    addr_q, addr_d;
  logic                          rd_q, rd_d;
  // The snapshot is consumed by shifting, so the next register is always in its low word.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    shift_d = shift_q;
    snap_d  = snap_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (i_start) begin
        snap_d  = i_rf_regs;
        shift_d = 32'(i_pc);
        byte_d  = '0;
        idx_d   = '0;
        phase_d = PH_PC;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: if (i_tx_done) begin
        shift_d = {shift_q[23:0], 8'h00};
        byte_d  = byte_q + 2'd1;
        state_d = SEND;
        if (byte_q == 2'd3) begin
          byte_d = '0;
          if (phase_q == PH_MEM) begin
            if (idx_q == IW'(MEM_WORDS - 1)) state_d = DONE;
            else begin
              idx_d   = idx_q + IW'(1);
              state_d = MEM_REQ;
            end
          end else if (phase_q == PH_PC || idx_q != IW'(NUM_REGS - 1)) begin
            shift_d = 32'(snap_q[PROC_BITS-1:0]);
            snap_d  = snap_q >> PROC_BITS;
            idx_d   = phase_q == PH_PC ? '0 : idx_q + IW'(1);
            phase_d = PH_REG;
          end else if (MEM_WORDS == 0) state_d = DONE;
          else begin
            idx_d   = '0;
            phase_d = PH_MEM;
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        shift_d = 32'(i_mem_data);
        state_d = SEND;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_data_d = state_d == SEND ? shift_d[31:24] : tx_data_q;
    addr_d    = state_d == MEM_REQ ? DATA_ADDRS_BITS'(idx_d) : addr_q;
    rd_d      = state_d == MEM_REQ ? 1'b1 : state_d == IDLE ? 1'b0 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_PC;
      shift_q   <= '0;
      snap_q    <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      shift_q   <= shift_d;
      snap_q    <= snap_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
    end
  end
  assign o_tx_start           = state_q == SEND;
  assign o_tx_data            = tx_data_q;
  assign o_debug_read_data    = rd_q;
  assign o_debug_read_address = addr_q;
  assign o_busy               = state_q != IDLE;
  assign o_done               = state_q == DONE;
endmodule

// File: tb/tb_debug_send_fsm.sv
// tb_debug_send_fsm: randomized dumps checked against a byte-stream model built from PC, registers and memory.
module tb_debug_send_fsm;
  localparam int NR = 4, MW = 2, AB = 3, TXLAT = 10, NB = 4 * (1 + NR + MW);
  logic clk = 0, rst = 1, i_start = 0, tx_extra = 0, tx_pulse = 0, tx_hold = 0;
  logic [31:0] i_pc = 0, i_mem_data = 0;
  logic [NR*32-1:0] i_rf_regs = '0;
  wire i_tx_done = tx_pulse | tx_extra;
  logic o_tx_start, o_debug_read_data, o_busy, o_done;
  logic [7:0] o_tx_data;
  logic [AB-1:0] o_debug_read_address;
  logic [31:0] tb_regs [NR];
  logic [31:0] mem [2**AB];
  int tests = 0, fails = 0, n_start = 0, n_done = 0, viol = 0, tx_cnt = 0;
  bit pending = 0, rd_at_done = 0;
  logic [7:0] rx_data [$];
  bit rx_rd [$];
  int rx_addr [$];
  logic [7:0] exp_q [$];

  debug_send_fsm #(.PC_BITS(32), .PROC_BITS(32), .NUM_REGS(NR), .DATA_ADDRS_BITS(AB), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pc(i_pc), .i_rf_regs(i_rf_regs),
    .i_mem_data(i_mem_data), .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_debug_read_data(o_debug_read_data), .o_debug_read_address(o_debug_read_address),
    .o_busy(o_busy), .o_done(o_done));

  always #5 clk = ~clk;
  always @(posedge clk) i_mem_data <= mem[o_debug_read_address];
  always @(posedge clk) begin
    if (rst) begin
      tx_cnt <= 0;
      tx_pulse <= 0;
    end else begin
      tx_pulse <= 0;
      if (o_tx_start) tx_cnt <= TXLAT;
      else if (tx_cnt > 0 && !tx_hold) begin
        tx_cnt <= tx_cnt - 1;
        if (tx_cnt == 1) tx_pulse <= 1;
      end
    end
  end
  always @(posedge clk) begin
    if (rst) pending = 0;
    else begin
      if (o_tx_start) begin
        if (pending) viol++;
        pending = 1;
        n_start++;
        rx_data.push_back(o_tx_data);
        rx_rd.push_back(o_debug_read_data);
        rx_addr.push_back(int'(o_debug_read_address));
      end
      if (tx_pulse) pending = 0;
      if (o_done) begin
        n_done++;
        rd_at_done = o_debug_read_data;
      end
    end
  end

  task automatic clear_mon;
    rx_data.delete(); rx_rd.delete(); rx_addr.delete();
    n_start = 0; n_done = 0; viol = 0; rd_at_done = 0;
  endtask

  task automatic load(input bit rnd);
    logic [31:0] words [$];
    logic [31:0] pc;
    pc = rnd ? $urandom : 32'h10;
    for (int k = 0; k < NR; k++) tb_regs[k] = rnd ? $urandom : 32'h11111111 * (k + 1);
    for (int a = 0; a < 2**AB; a++) mem[a] = rnd ? $urandom : 32'hA0A0A0A0 + a;
    i_pc = pc;
    for (int k = 0; k < NR; k++) i_rf_regs[k*32 +: 32] = tb_regs[k];
    words.push_back(pc);
    for (int k = 0; k < NR; k++) words.push_back(tb_regs[k]);
    for (int a = 0; a < MW; a++) words.push_back(mem[a]);
    exp_q.delete();
    foreach (words[w]) for (int b = 3; b >= 0; b--) exp_q.push_back(words[w][b*8 +: 8]);
  endtask

  task automatic pulse_start;
    @(negedge clk) i_start = 1;
    @(negedge clk) i_start = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (n_done > 0) ok = 1;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({o_tx_start, o_tx_data, o_debug_read_data, o_debug_read_address, o_busy, o_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs start=%b data=%h rd=%b addr=%h busy=%b done=%b, want all 0",
               o_tx_start, o_tx_data, o_debug_read_data, o_debug_read_address, o_busy, o_done);
    end
    rst = 0;
    clear_mon;
    repeat (20) @(negedge clk);
    tests++;
    if (n_start !== 0 || o_busy !== 0) begin
      fails++;
      $display("FAIL idle_quiet starts=%0d busy=%b, want 0 0", n_start, o_busy);
    end
  endtask

  task automatic test_basic;
    bit ok;
    load(0);
    clear_mon;
    pulse_start;
    tests++;
    if (o_tx_start !== 1 || o_busy !== 1 || o_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL first_send start=%b busy=%b data=%h, want 1 1 00", o_tx_start, o_busy, o_tx_data);
    end
    wait_done(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout no o_done within budget"); end
    tests++;
    if (rx_data.size() != NB) begin fails++; $display("FAIL basic_len got %0d want %0d", rx_data.size(), NB); end
    for (int i = 0; i < NB && i < rx_data.size(); i++) begin
      tests++;
      if (rx_data[i] !== exp_q[i]) begin fails++; $display("FAIL basic_byte[%0d] got %h want %h", i, rx_data[i], exp_q[i]); end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (n_done !== 1 || o_busy !== 0 || viol !== 0 || n_start !== NB) begin
      fails++;
      $display("FAIL basic_end done=%0d busy=%b viol=%0d starts=%0d, want 1 0 0 %0d", n_done, o_busy, viol, n_start, NB);
    end
  endtask

  task automatic test_latch;
    bit ok;
    load(1);
    clear_mon;
    pulse_start;
    i_pc = $urandom;
    for (int k = 0; k < NR; k++) i_rf_regs[k*32 +: 32] = $urandom;
    wait_done(ok);
    tests++;
    if (!ok || rx_data.size() != NB) begin fails++; $display("FAIL latch_len got %0d want %0d", rx_data.size(), NB); end
    for (int i = 0; i < NB && i < rx_data.size(); i++) begin
      tests++;
      if (rx_data[i] !== exp_q[i]) begin fails++; $display("FAIL latch_byte[%0d] got %h want %h", i, rx_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall;
    bit ok, stable;
    logic [7:0] b0;
    load(1);
    clear_mon;
    tx_hold = 1;
    pulse_start;
    b0 = o_tx_data;
    stable = 1;
    repeat (500) begin
      @(negedge clk);
      if (o_tx_data !== b0) stable = 0;
    end
    tests++;
    if (!stable || b0 !== exp_q[0] || n_start !== 1) begin
      fails++;
      $display("FAIL stall_hold stable=%b byte=%h starts=%0d, want 1 %h 1", stable, b0, n_start, exp_q[0]);
    end
    tx_hold = 0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (n_start == 2) ok = 1;
    end
    tests++;
    if (!ok || rx_data[1] !== exp_q[1]) begin fails++; $display("FAIL stall_release starts=%0d want 2", n_start); end
    wait_done(ok);
    tests++;
    if (!ok || rx_data != exp_q || viol !== 0) begin
      fails++;
      $display("FAIL stall_stream len=%0d viol=%0d, want %0d 0", rx_data.size(), viol, NB);
    end
  endtask

  task automatic test_ignore;
    bit ok;
    load(1);
    clear_mon;
    @(negedge clk) begin i_start = 1; tx_extra = 1; end
    @(negedge clk) begin i_start = 0; tx_extra = 0; end
    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge clk);
      if (n_done > 0) begin
        ok = 1;
        i_start = 0;
        tx_extra = 0;
      end else begin
        i_start = $urandom_range(3) == 0;
        tx_extra = o_tx_start;
      end
    end
    repeat (20) @(negedge clk);
    tests++;
    if (!ok || n_start !== NB || n_done !== 1) begin
      fails++;
      $display("FAIL ignore_counts starts=%0d done=%0d, want %0d 1", n_start, n_done, NB);
    end
    tests++;
    if (rx_data != exp_q) begin fails++; $display("FAIL ignore_stream len=%0d want %0d", rx_data.size(), NB); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int ns;
    load(0);
    clear_mon;
    pulse_start;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (rx_data.size() == 9) ok = 1;
    end
    rst = 1;
    @(negedge clk) rst = 0;
    tests++;
    if (!ok || {o_tx_start, o_tx_data, o_debug_read_data, o_debug_read_address, o_busy, o_done} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs reached=%b start=%b data=%h busy=%b, want 1 0 00 0", ok, o_tx_start, o_tx_data, o_busy);
    end
    ns = n_start;
    repeat (50) @(negedge clk);
    tests++;
    if (n_start !== ns || o_busy !== 0) begin fails++; $display("FAIL midreset_quiet starts=%0d want %0d", n_start, ns); end
    clear_mon;
    pulse_start;
    wait_done(ok);
    tests++;
    if (!ok || rx_data != exp_q) begin fails++; $display("FAIL midreset_restart len=%0d want %0d", rx_data.size(), NB); end
  endtask

  task automatic test_mem_phase;
    bit ok;
    load(1);
    clear_mon;
    pulse_start;
    tests++;
    if (o_debug_read_data !== 0) begin fails++; $display("FAIL memph_early rd=%b want 0", o_debug_read_data); end
    wait_done(ok);
    tests++;
    if (!ok || rx_rd.size() != NB) begin fails++; $display("FAIL memph_len got %0d want %0d", rx_rd.size(), NB); end
    for (int i = 0; i < NB && i < rx_rd.size(); i++) begin
      tests++;
      if (rx_rd[i] !== (i >= 4 * (1 + NR)) || (i >= 4 * (1 + NR) && rx_addr[i] != (i - 4 * (1 + NR)) / 4)) begin
        fails++;
        $display("FAIL memph_byte[%0d] rd=%b addr=%0d, want rd=%b addr=%0d", i, rx_rd[i], rx_addr[i],
                 i >= 4 * (1 + NR), (i - 4 * (1 + NR)) / 4);
      end
    end
    tests++;
    if (rd_at_done !== 1 || o_debug_read_data !== 0) begin
      fails++;
      $display("FAIL memph_done rd_at_done=%b rd_after=%b, want 1 0", rd_at_done, o_debug_read_data);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_latch;
    test_stall;
    test_ignore;
    test_reset_mid;
    test_mem_phase;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/debug_send_fsm.md
DEBUG_SEND_FSM -- requirements
Module: debug_send_fsm

Interface
REQ-001 Parameter PC_BITS, default 32: program-counter width; zero-extended to 32 bits for transmission.
REQ-002 Parameter PROC_BITS, default 32: register/data word width; fixed at 32 for byte framing.
REQ-003 Parameter NUM_REGS, default 32: register-file words transmitted.
REQ-004 Parameter DATA_ADDRS_BITS, default 7: data-memory word-address width.
REQ-005 Parameter MEM_WORDS, default 128: data-memory words transmitted, starting at address 0; MEM_WORDS <= 2**DATA_ADDRS_BITS.
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 i_start  input  1  dump request; sampled only in IDLE.
REQ-009 i_pc  input  PC_BITS  datapath program counter.
REQ-010 i_rf_regs  input  NUM_REGS*PROC_BITS  flattened register file; reg k at bits [k*32+31 : k*32].
REQ-011 i_mem_data  input  PROC_BITS  data-memory debug read word; valid one cycle after o_debug_read_address changes.
REQ-012 i_tx_done  input  1  UART transmitter one-cycle pulse: byte fully sent.
REQ-013 o_tx_start  output  1  one-cycle pulse: transmit o_tx_data.
REQ-014 o_tx_data  output  8  byte to transmit; registered.
REQ-015 o_debug_read_data  output  1  selects debug port of data memory.
REQ-016 o_debug_read_address  output  DATA_ADDRS_BITS  data-memory word address.
REQ-017 o_busy  output  1  high in every state except IDLE.
REQ-018 o_done  output  1  one-cycle pulse at dump completion.

Function
REQ-019 States: IDLE, SEND, WAIT_TX, MEM_REQ, MEM_WAIT, DONE.
REQ-020 Stream order: PC word, then reg 0..NUM_REGS-1, then mem 0..MEM_WORDS-1; each word 4 bytes, MSB first; total 4*(1+NUM_REGS+MEM_WORDS) bytes.
REQ-021 IDLE with i_start=1 at edge N: latch i_pc and i_rf_regs into a snapshot, load PC word into 32-bit shift register, byte count 0, word index 0, go to SEND; later input changes do not affect transmitted PC/register bytes.
REQ-022 SEND: for exactly one cycle o_tx_start=1 with o_tx_data = shift[31:24]; next state WAIT_TX; o_tx_start first high in the cycle after edge N.
REQ-023 o_tx_data holds its value from the o_tx_start cycle until the next o_tx_start.
REQ-024 WAIT_TX: wait indefinitely for i_tx_done; on it shift left 8 and increment byte count; if the word is incomplete go to SEND.
REQ-025 Word complete in register phase: load next snapshot register, go to SEND; after the last register go to MEM_REQ with memory address 0 (DONE if MEM_WORDS=0).
REQ-026 MEM_REQ: drive o_debug_read_address = current memory index, go to MEM_WAIT; MEM_WAIT: capture i_mem_data into shift register, go to SEND.
REQ-027 o_debug_read_data is high from entry to MEM_REQ until leaving DONE, low otherwise.
REQ-028 After last byte of mem MEM_WORDS-1 go to DONE; DONE: o_done=1 for one cycle, return to IDLE.
REQ-029 i_start outside IDLE ignored; i_tx_done outside WAIT_TX ignored; i_start and i_tx_done together in IDLE: start accepted, tx_done discarded.
REQ-030 Every counter compares against its terminal value and never wraps; byte count 2 bits, word index wide enough for max(NUM_REGS, MEM_WORDS).
REQ-031 At most one o_tx_start per i_tx_done; never two o_tx_start without an intervening i_tx_done.

Reset
REQ-032 rst=1 at any edge: state IDLE, all counters, shift register and snapshot zero; o_tx_start=0, o_tx_data=0, o_debug_read_data=0, o_debug_read_address=0, o_busy=0, o_done=0.
REQ-033 Reset mid-dump aborts with no further o_tx_start; a new i_start after reset begins again with the PC.

Verification (NUM_REGS=4, MEM_WORDS=2, DATA_ADDRS_BITS=3, tx model answers i_tx_done 10 cycles after o_tx_start)
REQ-034 i_pc=0x00000010, regs k=0x11111111*(k+1), mem[a]=0xA0A0A0A0+a, pulse i_start -> 28 bytes: 00 00 00 10, 11 11 11 11 .. 44 44 44 44, A0 A0 A0 A0, A0 A0 A0 A1; one o_done pulse; o_busy low afterwards.
REQ-035 Change i_pc and i_rf_regs one cycle after i_start -> transmitted bytes still the latched values.
REQ-036 Hold i_tx_done low 500 cycles after first o_tx_start -> o_tx_data stable, no second o_tx_start; release -> second byte follows.
REQ-037 Pulse i_start repeatedly mid-dump and pulse i_tx_done while in SEND -> stream and byte count unchanged, exactly 28 o_tx_start pulses.
REQ-038 Assert rst for one cycle after byte 9 -> all outputs zero next cycle, no o_tx_start until new i_start; new dump restarts with 00 00 00 10.
REQ-039 Check o_debug_read_address 0 then 1 and o_debug_read_data high only during the memory phase and DONE.
